// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared types and reset constants for down_counter.
//   state_t   - controller state (IDLE, RUN, HOLD, DONE), 2-bit encoding
//   STATE_RST - state after reset
//   TC_RST    - terminal-count pulse value after reset
//   DONE_RST  - done level after reset
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam logic   TC_RST    = 1'b0;
  localparam logic   DONE_RST  = 1'b0;

endpackage

// File: rtl/down_counter.sv
// down_counter: loadable countdown timer with terminal-count signalling.
// A start value is taken through a valid/ready handshake and decremented
// on every enabled clock. Reaching zero raises a one-cycle tc pulse and,
// in one-shot mode, parks in DONE with done held high.
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   en           - count enable (decrement only while counting)
//   clr          - synchronous abort: back to IDLE, count cleared
//   load_valid   - load request
//   load_value   - start value, sampled on handshake
//   load_ready   - high in IDLE and DONE
//   count        - registered current count
//   busy         - high in RUN or HOLD
//   tc           - registered one-cycle terminal-count pulse
//   done         - high in DONE
//
// Build option: define DOWN_COUNTER_AUTORELOAD_EN to reload the last
// loaded value at terminal count and keep running instead of stopping.
import down_counter_pkg::*;

module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q;
  logic             load_fire;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Pure decode of the state register; no input feeds load_ready.
  assign load_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == RUN)  || (state_q == HOLD);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (clr) begin
      // Abort wins over a pending load; reload value is retained.
      state_d = IDLE;
      count_d = '0;
    end else if (load_fire) begin
      if (load_value == '0) begin
        // Zero load is an immediate terminal count.
        state_d = DONE;
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
        count_d = load_value;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = load_value;
`endif
      end
    end else if (busy) begin
      if (en) begin
        if (count_q > WIDTH'(1)) begin
          state_d = RUN;
          count_d = count_q - WIDTH'(1);
        end else begin
          // count_q is 1 here (0 never survives into RUN/HOLD).
          tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
          state_d = RUN;
          count_d = reload_q;
`else
          state_d = DONE;
          count_d = '0;
`endif
        end
      end else begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_RST;
      count_q <= '0;
      tc_q    <= TC_RST;
      done_q  <= DONE_RST;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= (state_d == DONE);
    end
  end

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end
`endif

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule
